// File: rtl/load_store_unit.sv
// load_store_unit: sequences load/store requests from the MEM stage onto a word-only data memory.
// Sub-word stores are done as a read-modify-write over two memory cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; ready only in IDLE
//   req_write, req_size,     store flag, size (00 byte, 01 half, 10 word, 11 reserved),
//   req_unsigned, req_addr,  zero-extend flag for loads, byte address,
//   req_wdata                right-justified store data
//   resp_valid, resp_rdata,  one-cycle completion pulse, extended load data,
//   resp_err                 misaligned/reserved-size flag
//   busy                     request in flight, stalls the pipeline
//   mem_addr, mem_write,     word-aligned memory byte address, write strobe,
//   mem_wdata, mem_rdata     write word, combinational read word
// Optional feature: define LSU_MISALIGN_TRAP_EN to report misaligned or reserved-size
// requests as errors; otherwise the unused low address bits are ignored and size 11 acts as word.
module load_store_unit #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_write,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  lo;
    logic [1:0]  size;
    logic        uns;
    logic        wr;
    logic [31:0] wdata;
    logic        err;
    logic        unused_addr;

    assign unused_addr = ^req_addr[ADDR_W-1:MEM_ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
    assign err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign err = 1'b0;
`endif

    assign req_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign resp_valid = state == RESP;
    // Gated by rst so a reset sampled in WRITE suppresses the memory write.
    assign mem_write  = state == WRITE && !rst;

    // Half selection uses only a[1], so an unaligned half (untrapped) reads the aligned half.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] s, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        return s == 2'b00 ? {{24{b[7] & ~u}}, b} :
               s == 2'b01 ? {{16{h[15] & ~u}}, h} : w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] s, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (s == 2'b00)
            r[{a, 3'b000} +: 8] = d[7:0];
        else
            r[{a[1], 4'b0000} +: 16] = d[15:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lo         <= '0;
            size       <= '0;
            uns        <= 1'b0;
            wr         <= 1'b0;
            wdata      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lo         <= req_addr[1:0];
                    size       <= req_size;
                    uns        <= req_unsigned;
                    wr         <= req_write;
                    wdata      <= req_wdata;
                    mem_addr   <= {req_addr[MEM_ADDR_W-1:2], 2'b00};
                    mem_wdata  <= req_wdata;
                    resp_err   <= err;
                    resp_rdata <= '0;
                    state      <= err ? RESP : (req_write && req_size[1]) ? WRITE : READ;
                end
                READ: begin
                    if (wr)
                        mem_wdata <= merge(mem_rdata, lo, size, wdata);
                    else
                        resp_rdata <= extract(mem_rdata, lo, size, uns);
                    state <= wr ? WRITE : RESP;
                end
                WRITE: state <= RESP;
                RESP: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [4:0]  mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [8];
    logic [7:0]  mb [32];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    int tests = 0;
    int fails = 0;

    load_store_unit #(.ADDR_W(32), .MEM_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[4:2]];

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[4:2]] <= mem_wdata;
        else if (pre_we)
            mem[pre_a] <= pre_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int i);
        return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    endfunction

    task automatic preload(input int i, input logic [31:0] w);
        pre_a  = 3'(i);
        pre_d  = w;
        pre_we = 1'b1;
        for (int j = 0; j < 4; j++) mb[4*i+j] = w[8*j +: 8];
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called at a negedge while the DUT is idle; observes cycles 1..4 after the accept cycle.
    task automatic do_req(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                          input logic [31:0] d, input logic hold, output logic [31:0] rd);
        logic        err;
        int          nb, lat, wcyc, got_resp, got_wr, resp_n, wr_n;
        logic [4:0]  ea;
        logic [31:0] v, exp_rd, exp_w, got_rd, got_w;
        logic        got_err, ok_addr, ok_busy;
        err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        err = s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`endif
        nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
        ea = a[4:0] & 5'(~(nb - 1));
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mb[int'(ea) + i]) << (8 * i));
        exp_rd = '0;
        if (!w && !err)
            exp_rd = (!u && nb < 4 && v[8*nb-1]) ? (v | (32'hFFFF_FFFF << (8 * nb))) : v;
        lat  = err ? 1 : (w && nb < 4) ? 3 : 2;
        wcyc = (w && !err) ? lat - 1 : -1;
        if (w && !err)
            for (int i = 0; i < nb; i++) mb[int'(ea) + i] = d[8*i +: 8];
        exp_w = mword(int'(ea[4:2]));
        req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u;
        req_addr = a; req_wdata = d;
        check("ready_at_accept", {31'b0, req_ready}, 32'd1);
        got_resp = -1; got_wr = -1; resp_n = 0; wr_n = 0;
        got_rd = '0; got_w = '0; got_err = 1'b0; ok_addr = 1'b1; ok_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                resp_n++; got_resp = k; got_rd = resp_rdata; got_err = resp_err;
            end
            if (mem_write) begin
                wr_n++; got_wr = k; got_w = mem_wdata;
            end
            if (k <= lat && mem_addr != {a[4:2], 2'b00}) ok_addr = 1'b0;
            if (busy != (k <= lat) || req_ready != (k > lat)) ok_busy = 1'b0;
            if (hold && k <= lat) begin
                req_write = 1'b1; req_size = 2'($urandom); req_addr = $urandom;
                req_wdata = $urandom;
            end else
                req_valid = 1'b0;
        end
        check("resp_cycle", got_resp, lat);
        check("resp_count", resp_n, 1);
        check("resp_rdata", got_rd, exp_rd);
        check("resp_err", {31'b0, got_err}, {31'b0, err});
        check("write_cycle", got_wr, wcyc);
        check("write_count", wr_n, (w && !err) ? 1 : 0);
        if (w && !err) check("mem_wdata", got_w, exp_w);
        check("mem_addr_stable", {31'b0, ok_addr}, 32'd1);
        check("busy_ready", {31'b0, ok_busy}, 32'd1);
        check("mem_word", mem[ea[4:2]], exp_w);
        rd = got_rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        seen;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) preload(i, $urandom);
        rst = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF, 1'b0, rd);
        check("sw_mem", mem[2], 32'hDEAD_BEEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, 1'b0, rd);
        check("lb_0b", rd, 32'hFFFF_FFDE);
        do_req(1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, 1'b0, rd);
        check("lbu_0b", rd, 32'h0000_00DE);
        do_req(1'b0, 2'd1, 1'b0, 32'h08, 32'h0, 1'b0, rd);
        check("lh_08", rd, 32'hFFFF_BEEF);
        do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 1'b0, rd);
        check("lhu_0a", rd, 32'h0000_DEAD);
        do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h55, 1'b0, rd);
        check("sb_mem", mem[2], 32'hDEAD_55EF);
        do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h1234, 1'b0, rd);
        check("sh_mem", mem[2], 32'h1234_55EF);
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0, rd);
        do_req(1'b1, 2'd1, 1'b0, 32'h05, 32'hA5A5, 1'b0, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, rd);

        // Reset during the READ cycle of a byte store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h04;
        req_wdata = 32'h0000_00C3;
        seen = 1'b0;
        @(negedge clk);
        seen = seen | mem_write | resp_valid;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstr_busy", {31'b0, busy}, 32'd0);
        check("rstr_mem_addr", {27'b0, mem_addr}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen = seen | mem_write | resp_valid;
            @(negedge clk);
        end
        check("rstr_no_activity", {31'b0, seen}, 32'd0);
        check("rstr_mem_word", mem[1], mword(1));

        // Reset during the WRITE cycle of a word store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0C;
        req_wdata = ~mword(3);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = resp_valid;
        @(negedge clk);
        seen = seen | resp_valid | mem_write;
        check("rstw_no_resp", {31'b0, seen}, 32'd0);
        check("rstw_mem_word", mem[3], mword(3));

        for (int n = 0; n < 300; n++) begin
            logic w;
            w = 1'($urandom);
            do_req(w, 2'($urandom), 1'($urandom), $urandom, $urandom,
                   !w && ($urandom_range(3) == 0), rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the MEM pipeline stage and the word-only data memory. Accepts one load/store request at a time, issues word-aligned reads and writes to the data memory, and returns sign- or zero-extended load data. Sub-word stores (sb/sh) are handled as a read-modify-write over two memory cycles. `busy` stalls the pipeline while a request is in flight.

## Interface
- `ADDR_W`, 32: request byte-address width.
- `MEM_ADDR_W`, 5: data-memory byte-address width; the memory word-aligns internally as addr>>2.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present; sampled only while `req_ready`=1.
- `req_ready` out 1: 1 in IDLE only.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse, completion of the accepted request.
- `resp_rdata` out 32: extended load data, valid with `resp_valid`; 0 for stores and errors.
- `resp_err` out 1: misaligned or reserved-size request, valid with `resp_valid`.
- `busy` out 1: state != IDLE.
- `mem_addr` out MEM_ADDR_W: word-aligned byte address, low 2 bits always 0.
- `mem_write` out 1: write strobe to the data memory.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: combinational read data for `mem_addr`.

## Operation
- FSM states are IDLE, READ, WRITE and RESP. All outputs are registered or decoded from state.
- On accept (IDLE with `req_valid`), the unit latches the address, size, unsigned flag, write flag and data. It sets `mem_addr` = {req_addr[MEM_ADDR_W-1:2],2'b00}, truncating the upper bits.
- Next state after accept:
  - Error: RESP.
  - Load: READ.
  - Word store: WRITE.
  - Byte or half store: READ.
- READ captures `mem_rdata` into a word register at the end of the cycle. Next state is RESP for a load, WRITE for a store.
- WRITE asserts `mem_write`=1 for exactly this cycle. `mem_wdata` is:
  - Word store: the stored word.
  - Byte or half store: the captured word with the target lane(s) replaced.
  - Next state is RESP.
- RESP asserts `resp_valid`=1. Next state is IDLE.
- Byte lanes are little-endian. Byte lane k = bits [8k+7:8k] with k = addr[1:0]. The half at addr[1]=h occupies bits [16h+15:16h].
- Load extraction:
  - Byte: lane k, extended from bit 7.
  - Half: the half selected by h, extended from bit 15.
  - Word: unchanged.
- Store merge: byte data = req_wdata[7:0]; half data = req_wdata[15:0]. All other lanes are kept from the captured word.
- An error request performs no memory write, and its response has `resp_rdata`=0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency from the accept cycle (cycle 0) to `resp_valid`:
  - Error: cycle 1.
  - Word store: cycle 2, with `mem_write` in cycle 1.
  - Load: cycle 2.
  - Sub-word store: cycle 3, with `mem_write` in cycle 2.
- The earliest next accept is the cycle after RESP. There is no back-to-back overlap.
- `req_valid` while not in IDLE is ignored and not queued. The pipeline must hold its request while `busy`=1.
- `rst` asserted in any state: the next cycle is IDLE with all outputs at reset values. An in-flight request is dropped. If reset is sampled in WRITE, the write is not performed.
- `mem_addr` stays stable from the cycle after accept through RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half with addr[0]=1, word with addr[1:0]≠0, or size 11 is an error. The response comes in cycle 1 with `resp_err`=1 and there is no memory access.
- Not defined:
  - `resp_err` is tied 0.
  - The low address bits that a half or word access does not use are ignored: half uses addr[1], word ignores addr[1:0].
  - Size 11 is treated as word.

## Test plan
- After reset: `req_ready`=1, `busy`=0, and all outputs 0. sw 0xDEADBEEF @0x08: `mem_write`=1 in cycle 1 with `mem_addr`=0x08; `resp_valid` in cycle 2.
- Preload 0xDEADBEEF @0x08:
  - lb @0x0B gives 0xFFFFFFDE.
  - lbu @0x0B gives 0x000000DE.
  - lh @0x08 gives 0xFFFFBEEF.
  - lhu @0x0A gives 0x0000DEAD.
  - Each response arrives in cycle 2.
- Preload 0xDEADBEEF @0x08:
  - sb 0x55 @0x09 writes 0xDEAD55EF, with `mem_write` in cycle 2 only.
  - sh 0x1234 @0x0A then writes 0x123455EF.
- With `LSU_MISALIGN_TRAP_EN`: lw @0x06 gives `resp_err`=1 and `resp_rdata`=0 in cycle 1, with no write. sh @0x05 gives `resp_err`=1 and the memory is unchanged. Without the macro: lw @0x06 returns the word @0x04 with `resp_err`=0.
- `req_valid` held high with new requests throughout a load: only the first is accepted. The next accept happens the cycle after `resp_valid`.
- `rst` pulsed during the READ cycle of sb @0x04: the next cycle is IDLE, `mem_write` never asserts, and no `resp_valid` is produced.
